// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and types for the FIFO read-side width upsizer.
package fifo_rd_packer_pkg;

    // Default width of one FIFO word and words packed per output beat.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK_RATIO = 4;

    // Wide beat and lane-keep types at the default geometry.
    typedef logic [DEF_DATA_WIDTH*DEF_PACK_RATIO-1:0] packed_beat_t;
    typedef logic [DEF_PACK_RATIO-1:0]                lane_keep_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Narrow input stream, flush request and wide output stream of the packer.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; the source holds valid and data stable
// until that edge, and ready may depend combinationally on the sink's state.
//
// master: the packer itself. slave: the environment (FIFO read port upstream,
// wide consumer downstream).
interface fifo_rd_packer_if
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK_RATIO = DEF_PACK_RATIO
);
    logic                             s_valid;
    logic [DATA_WIDTH-1:0]            s_data;
    logic                             s_ready;
    logic                             flush;
    logic                             m_valid;
    logic [DATA_WIDTH*PACK_RATIO-1:0] m_data;
    logic [PACK_RATIO-1:0]            m_keep;
    logic                             m_ready;

    modport master (
        input  s_valid, s_data, flush, m_ready,
        output s_ready, m_valid, m_data, m_keep
    );

    modport slave (
        output s_valid, s_data, flush, m_ready,
        input  s_ready, m_valid, m_data, m_keep
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side width upsizer: packs PACK_RATIO narrow words into one wide beat.
// An assembly buffer collects words lane by lane (lane 0 first, least
// significant); a full buffer, or a pending flush with data, moves into the
// output register. s_ready looks through to m_ready so a full buffer behind a
// draining output register still accepts one word per cycle.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  PACK_RATIO = DEF_PACK_RATIO,
    localparam int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    fifo_rd_packer_if.master      bus
);

    localparam int                   BEAT_WIDTH = DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL   = CNT_WIDTH'(PACK_RATIO);

    // Assembly buffer
    logic [BEAT_WIDTH-1:0] lanes;
    logic [BEAT_WIDTH-1:0] lanes_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  flush_pend;
    logic                  flush_pend_next;

    // Output register
    logic                  m_valid_r;
    logic [BEAT_WIDTH-1:0] m_data_r;
    logic [PACK_RATIO-1:0] m_keep_r;
    logic [PACK_RATIO-1:0] keep_from_cnt;

    logic full;
    logic move;
    logic s_ready;
    logic accept;

    // Move/accept decisions; s_ready is combinational from m_ready via move.
    always_comb begin
        full    = (cnt == CNT_FULL);
        move    = (full || (flush_pend && (cnt != '0))) && (!m_valid_r || bus.m_ready);
        s_ready = !flush_pend && (!full || move);
        accept  = bus.s_valid && s_ready;
    end

    // Lane mask for the beat being moved: lanes below the fill count hold data.
    always_comb begin
        keep_from_cnt = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            keep_from_cnt[i] = (CNT_WIDTH'(i) < cnt);
        end
    end

    // Next assembly state: a move empties the buffer (zeroing every lane) and
    // a same-cycle word restarts it in lane 0; otherwise words fill lane cnt.
    always_comb begin
        lanes_next = lanes;
        cnt_next   = cnt;
        if (move) begin
            lanes_next = '0;
            cnt_next   = '0;
            if (accept) begin
                lanes_next[DATA_WIDTH-1:0] = bus.s_data;
                cnt_next                   = CNT_WIDTH'(1);
            end
        end else if (accept) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (cnt == CNT_WIDTH'(i)) begin
                    lanes_next[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
                end
            end
            cnt_next = cnt + CNT_WIDTH'(1);
        end
    end

    // Flush request: latched once, cleared by the move it causes or at once
    // when there is nothing to flush; a repeat request while pending is dropped.
    always_comb begin
        flush_pend_next = flush_pend;
        if (flush_pend) begin
            if (move || (cnt == '0)) begin
                flush_pend_next = 1'b0;
            end
        end else begin
            flush_pend_next = bus.flush;
        end
    end

    // Assembly buffer registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            lanes      <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            lanes      <= lanes_next;
            cnt        <= cnt_next;
            flush_pend <= flush_pend_next;
        end
    end

    // Output register: loads on a move, holds while stalled, drops valid on take.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_keep_r  <= '0;
        end else if (move) begin
            m_valid_r <= 1'b1;
            m_data_r  <= lanes;
            m_keep_r  <= keep_from_cnt;
        end else if (bus.m_ready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_keep  = m_keep_r;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side width upsizer placed directly downstream of the async FIFO's read port, in the `rclk` domain. It accepts `DATA_WIDTH` words over a valid/ready handshake and packs `PACK_RATIO` consecutive words into one wide output beat. An optional flush pulse emits a partially filled beat, with a lane-keep mask marking which lanes hold data. It decouples the FIFO's narrow word stream from a wide downstream consumer, sustaining one input word per cycle.

## Interface
- `DATA_WIDTH`, default: package constant; width of one input word, matching the FIFO `r_data`.
- `PACK_RATIO`, default 4; words per output beat; must be ≥ 2.
- `CNT_WIDTH`, default $clog2(PACK_RATIO+1); width of the fill counter (derived, not overridden).
- `rclk`  in  1  single clock; all state is on its rising edge.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input word available; driven by the FIFO `r_valid`.
- `s_data`  in  DATA_WIDTH  input word; valid whenever `s_valid` is high (first-word-fall-through).
- `s_ready`  out  1  word consumed this cycle; drives the FIFO `r_ready`.
- `flush`  in  1  single-cycle request to emit the current partial beat.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  DATA_WIDTH*PACK_RATIO  packed beat; lane i is at [i*DATA_WIDTH +: DATA_WIDTH].
- `m_keep`  out  PACK_RATIO  bit i set when lane i holds data.
- `m_ready`  in  1  downstream accepts the beat.

## Operation
- Two storage stages:
  - **Assembly buffer**: `PACK_RATIO` lanes plus fill count `cnt` (0..PACK_RATIO).
  - **Output register**: `m_data`, `m_keep`, `m_valid`.
- Input accept: `s_valid && s_ready`. The word is written to lane `cnt`, and `cnt` increments. The first word of a beat lands in lane 0, which holds the least-significant bits.
- Move condition: `(cnt == PACK_RATIO || (flush_pend && cnt != 0)) && (!m_valid || m_ready)`.
- On a move:
  - All lanes are copied to `m_data`; unfilled lanes are copied as zero.
  - `m_keep` is set to `(1<<cnt)-1`.
  - `m_valid` is set to 1.
  - `cnt` is cleared to 0, or to 1 if an input is accepted in the same cycle. That word goes to lane 0.
  - Lanes not refilled are zeroed.
- `s_ready = !flush_pend && (cnt != PACK_RATIO || move)`. It is combinational from `m_ready`, so a full assembly buffer and a draining output register still give full throughput.
- Flush handling:
  - `flush` sets `flush_pend`.
  - A word accepted in the same cycle as `flush` is included in the flushed beat.
  - `flush_pend` clears on the move it causes.
  - If `cnt == 0` with no same-cycle accept, `flush_pend` clears on the next cycle and no beat is produced.
  - `flush` while `flush_pend` is already set is ignored.
- Output handshake:
  - `m_valid` clears on `m_ready` unless a new move occurs in the same cycle.
  - `m_data` and `m_keep` stay stable while `m_valid && !m_ready`.
- Reset mid-operation discards the partial assembly and any undelivered beat.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `m_keep` = 0.
  - `cnt` = 0, `flush_pend` = 0, all lanes = 0.
  - `s_ready` = 1 (combinational, once out of reset).
- Latency: when the word completing a beat is accepted at edge E, `m_valid` rises after edge E+1, provided the output register is free.
- Flush latency: with `flush` at edge E and `cnt > 0`, `m_valid` rises after edge E+1.
- Throughput: with `m_ready` held high, one word is accepted per cycle indefinitely; there are no bubbles at beat boundaries.
- Backpressure: with `m_ready` low and both stages full, `s_ready` stays 0 until the cycle `m_ready` rises. In that cycle, the move and a new accept both occur.

## Structure
- Add to `async_fifo_package`:
  - `PACK_RATIO` default.
  - `typedef logic [DATA_WIDTH*PACK_RATIO-1:0] packed_beat_t`.
  - `typedef logic [PACK_RATIO-1:0] lane_keep_t`.
- A single module; no sub-module is required.
- Top-level integration wires the FIFO `r_valid`/`r_ready`/`r_data` to `s_valid`/`s_ready`/`s_data`, with `rclk` shared and `rrst_n = ~rrst`.

## Test plan
All scenarios use `DATA_WIDTH`=8 and `PACK_RATIO`=4.
- **Full beat:** 0x11, 0x22, 0x33, 0x44 back-to-back with `m_ready`=1 → one beat `m_data`=0x44332211, `m_keep`=4'b1111, `m_valid` one cycle after the 0x44 accept.
- **Streaming:** 12 consecutive words 0x01..0x0C with `m_ready`=1 → `s_ready` never drops; beats 0x04030201, 0x08070605, 0x0C0B0A09.
- **Partial flush:** 0xAA, 0xBB, then `flush` → beat 0x0000BBAA, `m_keep`=4'b0011. A flush coinciding with the 0xBB accept gives the same result.
- **Empty flush:** `flush` with `cnt`=0 → no `m_valid`; `s_ready` low for exactly one cycle.
- **Backpressure:** `m_ready`=0 while feeding 8 words → first beat held stable, second assembled, `s_ready`=0. Raising `m_ready` → both beats are delivered in order with no word lost.
- **Mid-operation reset:** `rrst_n` asserted after 2 words with a beat pending → all outputs are 0 immediately. After release, the next 4 words form a clean beat with `m_keep`=4'b1111.
